// File: rtl/cim_pkg.sv
// Shared types for the CIM row-batch copy sequencer.
package cim_pkg;

    localparam int ROW_AW_DEF = 8;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WAIT,
        WR,
        DONE
    } state_e;

    typedef enum logic {
        DIR_ASC  = 1'b0,
        DIR_DESC = 1'b1
    } dir_e;

endpackage

// File: rtl/cim_cmd_checker.sv
// Combinational legality and copy-direction check for a row-copy command.
module cim_cmd_checker
    import cim_pkg::*;
#(
    parameter int ROW_AW = ROW_AW_DEF
) (
    input  logic [ROW_AW-1:0] src_i,
    input  logic [ROW_AW-1:0] dst_i,
    input  logic [ROW_AW:0]   len_i,
    output logic              cmd_ok_o,
    output dir_e              dir_o
);

    localparam logic [ROW_AW+1:0] ROWS = {2'b01, {ROW_AW{1'b0}}};

    logic [ROW_AW+1:0] src_end;
    logic [ROW_AW+1:0] dst_end;

    assign src_end = {2'b00, src_i} + {1'b0, len_i};
    assign dst_end = {2'b00, dst_i} + {1'b0, len_i};

    always_comb begin
        cmd_ok_o = (len_i != '0) && (src_end <= ROWS) && (dst_end <= ROWS);
        dir_o    = DIR_ASC;
        // Destination overlapping the tail of the source must be copied top-down.
        if ((dst_i > src_i) && ({2'b00, dst_i} < src_end)) begin
            dir_o = DIR_DESC;
        end
    end

endmodule

// File: rtl/cim_row_batch_sequencer.sv
// Copies a block of CIM array rows one row at a time (read, wait, write).
module cim_row_batch_sequencer
    import cim_pkg::*;
#(
    parameter int ROW_AW = ROW_AW_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_LAT = 1
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ROW_AW-1:0] cmd_src,
    input  logic [ROW_AW-1:0] cmd_dst,
    input  logic [ROW_AW:0]   cmd_len,
    input  logic              abort,
    output logic [ROW_AW-1:0] arr_addr,
    output logic              arr_en,
    output logic              arr_we,
    output logic [DATA_W-1:0] arr_wdata,
    input  logic [DATA_W-1:0] arr_rdata,
    input  logic              arr_busy,
    output logic              busy,
    output logic              done_irq,
    output logic              err_irq,
    output logic [ROW_AW:0]   rows_done
);

    localparam int         PW       = ROW_AW + 1;
    localparam logic [2:0] LAT_LAST = 3'(RD_LAT - 1);

    state_e            state_q, state_d;
    dir_e              dir_q, dir_d;
    dir_e              chk_dir;
    logic              chk_ok;
    logic [PW-1:0]     src_q, src_d;
    logic [PW-1:0]     dst_q, dst_d;
    logic [PW-1:0]     rem_q, rem_d;
    logic [PW-1:0]     rows_q, rows_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [2:0]        lat_q, lat_d;
    logic              err_q, err_d;

    cim_cmd_checker #(
        .ROW_AW (ROW_AW)
    ) u_chk (
        .src_i    (cmd_src),
        .dst_i    (cmd_dst),
        .len_i    (cmd_len),
        .cmd_ok_o (chk_ok),
        .dir_o    (chk_dir)
    );

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dir_q   <= DIR_ASC;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            rows_q  <= '0;
            data_q  <= '0;
            lat_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            rows_q  <= rows_d;
            data_q  <= data_d;
            lat_q   <= lat_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        src_d     = src_q;
        dst_d     = dst_q;
        rem_d     = rem_q;
        rows_d    = rows_q;
        data_d    = data_q;
        lat_d     = lat_q;
        err_d     = 1'b0;
        cmd_ready = 1'b0;
        arr_en    = 1'b0;
        arr_we    = 1'b0;
        arr_addr  = '0;
        done_irq  = 1'b0;

        unique case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (chk_ok) begin
                        state_d = RD;
                        dir_d   = chk_dir;
                        rows_d  = '0;
                        rem_d   = cmd_len;
                        if (chk_dir == DIR_DESC) begin
                            src_d = {1'b0, cmd_src} + cmd_len - PW'(1);
                            dst_d = {1'b0, cmd_dst} + cmd_len - PW'(1);
                        end else begin
                            src_d = {1'b0, cmd_src};
                            dst_d = {1'b0, cmd_dst};
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RD: begin
                if (!arr_busy) begin
                    arr_en   = 1'b1;
                    arr_addr = src_q[ROW_AW-1:0];
                    lat_d    = '0;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (lat_q == LAT_LAST) begin
                    data_d  = arr_rdata;
                    state_d = WR;
                end else begin
                    lat_d = lat_q + 3'd1;
                end
            end
            WR: begin
                if (!arr_busy) begin
                    arr_en   = 1'b1;
                    arr_we   = 1'b1;
                    arr_addr = dst_q[ROW_AW-1:0];
                    rows_d   = rows_q + PW'(1);
                    rem_d    = rem_q - PW'(1);
                    if (dir_q == DIR_DESC) begin
                        src_d = src_q - PW'(1);
                        dst_d = dst_q - PW'(1);
                    end else begin
                        src_d = src_q + PW'(1);
                        dst_d = dst_q + PW'(1);
                    end
                    state_d = (rem_q == PW'(1)) ? DONE : RD;
                end
            end
            DONE: begin
                done_irq = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort overrides whatever the current state would have issued.
        if (abort && (state_q != IDLE)) begin
            state_d  = IDLE;
            arr_en   = 1'b0;
            arr_we   = 1'b0;
            arr_addr = '0;
            done_irq = 1'b0;
            err_d    = 1'b1;
            src_d    = src_q;
            dst_d    = dst_q;
            rem_d    = rem_q;
            rows_d   = rows_q;
            data_d   = data_q;
            lat_d    = lat_q;
        end
    end

    assign arr_wdata = data_q;
    assign busy      = (state_q != IDLE);
    assign err_irq   = err_q;
    assign rows_done = rows_q;

endmodule

// File: tb/tb_cim_row_batch_sequencer.sv
// Self-checking bench: memmove-style reference model of the row copier.
module tb_cim_row_batch_sequencer;

    localparam int AW      = 8;
    localparam int DW      = 32;
    localparam int NR      = 1 << AW;
    localparam int PER_ROW = 3;

    logic          clk_in    = 1'b0;
    logic          rst_n     = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_src   = '0;
    logic [AW-1:0] cmd_dst   = '0;
    logic [AW:0]   cmd_len   = '0;
    logic          abort     = 1'b0;
    logic [AW-1:0] arr_addr;
    logic          arr_en;
    logic          arr_we;
    logic [DW-1:0] arr_wdata;
    logic [DW-1:0] arr_rdata = '0;
    logic          arr_busy  = 1'b0;
    logic          busy;
    logic          done_irq;
    logic          err_irq;
    logic [AW:0]   rows_done;

    always #5 clk_in = ~clk_in;

    cim_row_batch_sequencer #(
        .ROW_AW (AW),
        .DATA_W (DW),
        .RD_LAT (1)
    ) dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_src   (cmd_src),
        .cmd_dst   (cmd_dst),
        .cmd_len   (cmd_len),
        .abort     (abort),
        .arr_addr  (arr_addr),
        .arr_en    (arr_en),
        .arr_we    (arr_we),
        .arr_wdata (arr_wdata),
        .arr_rdata (arr_rdata),
        .arr_busy  (arr_busy),
        .busy      (busy),
        .done_irq  (done_irq),
        .err_irq   (err_irq),
        .rows_done (rows_done)
    );

    // Array model (1-cycle read latency) and access/event monitor.
    logic [DW-1:0] mem [NR];
    logic [AW-1:0] q_addr [$];
    logic          q_we   [$];
    logic [DW-1:0] q_data [$];
    int            cyc       = 0;
    int            done_cnt  = 0;
    int            err_cnt   = 0;
    int            done_cyc  = 0;
    int            busy_viol = 0;
    int            addr_viol = 0;
    logic          fill_req  = 1'b0;
    logic [DW-1:0] fill_seed = '0;

    always @(posedge clk_in) begin
        cyc <= cyc + 1;
        if (fill_req) begin
            for (int i = 0; i < NR; i++)
                mem[i] <= fill_seed ^ (32'(i) * 32'h9E3779B1);
        end else if (arr_en && arr_we) begin
            mem[arr_addr] <= arr_wdata;
        end
        if (arr_en && !arr_we) arr_rdata <= mem[arr_addr];
        if (arr_en) begin
            q_addr.push_back(arr_addr);
            q_we.push_back(arr_we);
            q_data.push_back(arr_wdata);
        end
        if (arr_en && arr_busy) busy_viol <= busy_viol + 1;
        if (!arr_en && (arr_addr != '0)) addr_viol <= addr_viol + 1;
        if (done_irq) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (err_irq) err_cnt <= err_cnt + 1;
    end

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] snap [NR];
    logic [AW-1:0] e_addr [$];
    logic          e_we   [$];
    logic [DW-1:0] e_data [$];
    int            k0, log0, done0, err0;
    int            cur_src, cur_dst, cur_len;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic [DW-1:0] seed);
        @(negedge clk_in);
        fill_seed = seed;
        fill_req  = 1'b1;
        @(negedge clk_in);
        fill_req  = 1'b0;
    endtask

    function automatic int seq_mism(input int n);
        int m = 0;
        for (int j = 0; j < n; j++) begin
            if (q_addr[log0+j] !== e_addr[j] || q_we[log0+j] !== e_we[j])
                m++;
            else if (e_we[j] && (q_data[log0+j] !== e_data[j]))
                m++;
        end
        return m;
    endfunction

    // Snapshot memory, build the expected access list, then issue.
    task automatic start_cmd(input int s, input int d, input int n);
        bit desc;
        @(negedge clk_in);
        for (int i = 0; i < NR; i++) snap[i] = mem[i];
        e_addr.delete();
        e_we.delete();
        e_data.delete();
        desc = (d > s) && (d < s + n);
        for (int j = 0; j < n; j++) begin
            int r;
            r = desc ? (n - 1 - j) : j;
            e_addr.push_back(AW'(s + r));
            e_we.push_back(1'b0);
            e_data.push_back(32'h0);
            e_addr.push_back(AW'(d + r));
            e_we.push_back(1'b1);
            e_data.push_back(snap[s + r]);
        end
        log0    = q_addr.size();
        done0   = done_cnt;
        err0    = err_cnt;
        cur_src = s;
        cur_dst = d;
        cur_len = n;
        chk("ready_before_cmd", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_src   = AW'(s);
        cmd_dst   = AW'(d);
        cmd_len   = (AW+1)'(n);
        @(posedge clk_in);
        k0 = cyc;
        #1 cmd_valid = 1'b0;
    endtask

    task automatic finish_copy(input int extra);
        int n;
        int m;
        for (int t = 0; t < 600 && done_cnt == done0 && err_cnt == err0; t++)
            @(negedge clk_in);
        chk("done_count", done_cnt - done0, 1);
        chk("done_latency", done_cyc - k0, cur_len * PER_ROW + 1 + extra);
        chk("no_err_on_copy", err_cnt - err0, 0);
        chk("rows_done", rows_done, cur_len);
        n = q_addr.size() - log0;
        chk("access_count", n, e_addr.size());
        if (n == e_addr.size()) chk("access_order", seq_mism(n), 0);
        m = 0;
        for (int i = 0; i < NR; i++) begin
            logic [DW-1:0] want;
            want = snap[i];
            if (i >= cur_dst && i < cur_dst + cur_len)
                want = snap[cur_src + i - cur_dst];
            if (mem[i] !== want) m++;
        end
        chk("memory_image", m, 0);
        @(negedge clk_in);
        chk("ready_after_done", cmd_ready, 1);
        chk("idle_after_done", busy, 0);
    endtask

    task automatic reject_cmd(input int s, input int d, input int n);
        int rows0;
        @(negedge clk_in);
        log0  = q_addr.size();
        err0  = err_cnt;
        done0 = done_cnt;
        rows0 = int'(rows_done);
        cmd_valid = 1'b1;
        cmd_src   = AW'(s);
        cmd_dst   = AW'(d);
        cmd_len   = (AW+1)'(n);
        @(posedge clk_in);
        #1 cmd_valid = 1'b0;
        @(negedge clk_in);
        chk("reject_err_pulse", err_irq, 1);
        chk("reject_ready", cmd_ready, 1);
        @(negedge clk_in);
        chk("reject_err_once", err_cnt - err0, 1);
        chk("reject_no_access", q_addr.size() - log0, 0);
        chk("reject_rows_kept", rows_done, rows0);
        chk("reject_idle", busy, 0);
    endtask

    initial begin
        int m;
        repeat (3) @(negedge clk_in);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_en", arr_en, 0);
        chk("rst_addr", arr_addr, 0);
        chk("rst_wdata", arr_wdata, 0);
        chk("rst_done", done_irq, 0);
        chk("rst_err", err_irq, 0);
        chk("rst_rows", rows_done, 0);
        rst_n = 1'b1;
        fill(32'h1234_5678);

        start_cmd(4, 20, 3);
        finish_copy(0);
        start_cmd(10, 12, 4);
        finish_copy(0);

        reject_cmd(5, 9, 0);
        reject_cmd(250, 3, 8);
        reject_cmd(3, 249, 8);
        reject_cmd(1, 0, 256);

        start_cmd(0, 248, 8);
        finish_copy(0);
        start_cmd(248, 0, 8);
        finish_copy(0);
        start_cmd(77, 77, 5);
        finish_copy(0);

        // Stall the second write of a two-row copy for five cycles.
        start_cmd(40, 70, 2);
        repeat (5) @(posedge clk_in);
        #1 arr_busy = 1'b1;
        m = 0;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk_in);
            if (arr_en !== 1'b0) m++;
            if (arr_wdata !== snap[41]) m += 2;
        end
        @(posedge clk_in);
        #1 arr_busy = 1'b0;
        chk("stall_en_and_wdata", m, 0);
        finish_copy(5);

        // Abort in the WAIT of the third row.
        start_cmd(120, 150, 5);
        repeat (7) @(posedge clk_in);
        #1 abort = 1'b1;
        @(negedge clk_in);
        chk("abort_en_low", arr_en, 0);
        @(posedge clk_in);
        #1 abort = 1'b0;
        @(negedge clk_in);
        chk("abort_err_pulse", err_irq, 1);
        chk("abort_ready", cmd_ready, 1);
        repeat (4) @(negedge clk_in);
        chk("abort_err_once", err_cnt - err0, 1);
        chk("abort_no_done", done_cnt - done0, 0);
        chk("abort_rows", rows_done, 2);
        chk("abort_access_count", q_addr.size() - log0, 5);
        if (q_addr.size() - log0 == 5) chk("abort_access_order", seq_mism(5), 0);
        chk("abort_row_written", mem[151], snap[121]);
        chk("abort_row_untouched", mem[152], snap[152]);

        // Abort coinciding with the final write.
        start_cmd(30, 40, 1);
        repeat (2) @(posedge clk_in);
        #1 abort = 1'b1;
        @(negedge clk_in);
        chk("abort_wr_en_low", arr_en, 0);
        @(posedge clk_in);
        #1 abort = 1'b0;
        repeat (3) @(negedge clk_in);
        chk("abort_wr_err", err_cnt - err0, 1);
        chk("abort_wr_no_done", done_cnt - done0, 0);
        chk("abort_wr_rows", rows_done, 0);
        chk("abort_wr_accesses", q_addr.size() - log0, 1);
        chk("abort_wr_mem", mem[40], snap[40]);
        start_cmd(30, 40, 1);
        finish_copy(0);

        // Reset in the middle of a copy.
        start_cmd(100, 60, 6);
        repeat (4) @(posedge clk_in);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_ready", cmd_ready, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_en", arr_en, 0);
        chk("midrst_addr", arr_addr, 0);
        chk("midrst_rows", rows_done, 0);
        chk("midrst_done", done_irq, 0);
        chk("midrst_err", err_irq, 0);
        chk("midrst_wdata", arr_wdata, 0);
        repeat (2) @(negedge clk_in);
        rst_n = 1'b1;
        @(negedge clk_in);
        chk("postrst_ready", cmd_ready, 1);
        start_cmd(100, 60, 6);
        finish_copy(0);

        fill(32'hCAFE_F00D);
        for (int t = 0; t < 25; t++) begin
            int n, s, d;
            n = $urandom_range(0, 12);
            s = $urandom_range(0, NR - 1);
            if ($urandom_range(0, 1) == 1) begin
                d = s + int'($urandom_range(0, 2 * n)) - n;
                if (d < 0) d = 0;
                if (d > NR - 1) d = NR - 1;
            end else begin
                d = $urandom_range(0, NR - 1);
            end
            if (n == 0 || s + n > NR || d + n > NR) begin
                reject_cmd(s, d, n);
            end else begin
                start_cmd(s, d, n);
                finish_copy(0);
            end
        end

        chk("never_access_while_busy", busy_viol, 0);
        chk("addr_zero_when_idle", addr_viol, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cim_row_batch_sequencer.md
Name: cim_row_batch_sequencer

Overview:
- Command-driven sequencer that copies a contiguous block of CIM array rows, one row at a time, from a source base row to a destination base row.
- Sits between the register set and the CIM array: accepts a command from reg_set and issues the read/write cycles to the array.
- Tolerates array stalls, handles overlapping ranges, supports abort, and reports completion or error through one-cycle interrupt pulses.

Parameters:
ROW_AW, 8, row address width; the array has 2**ROW_AW rows
DATA_W, 32, row data width
RD_LAT, 1, array read latency in cycles (min 1, max 7)

Ports:
clk_in  in  1  system clock (HCLK domain)
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE; command accepted when cmd_valid and cmd_ready are both high
cmd_src  in  ROW_AW  source base row
cmd_dst  in  ROW_AW  destination base row
cmd_len  in  ROW_AW+1  number of rows to copy
abort  in  1  cancel the command in progress
arr_addr  out  ROW_AW  array row address
arr_en  out  1  array access enable
arr_we  out  1  array write enable (qualified by arr_en)
arr_wdata  out  DATA_W  write data
arr_rdata  in  DATA_W  read data, valid RD_LAT cycles after the read cycle
arr_busy  in  1  array busy; the sequencer issues no access while high
busy  out  1  high in any state other than IDLE
done_irq  out  1  one-cycle pulse on successful completion
err_irq  out  1  one-cycle pulse on a rejected command or on abort
rows_done  out  ROW_AW+1  count of rows written for the current or last command

Behaviour:
- Reset values: all outputs 0 except cmd_ready=1. State is IDLE; pointers, counters and the data register are 0.
- Reset mid-operation: immediate return to IDLE with reset values. No write is completed.
- Acceptance checks, done combinationally on the command inputs in IDLE:
  - cmd_len==0, or cmd_src+cmd_len > 2**ROW_AW, or cmd_dst+cmd_len > 2**ROW_AW: reject.
  - On reject: err_irq pulses the next cycle, no array access occurs, the FSM stays in IDLE and rows_done is unchanged.
- Copy direction, decided on a valid accept:
  - Descending when cmd_dst > cmd_src and cmd_dst < cmd_src+cmd_len (overlap). Pointers start at src+len-1 and dst+len-1 and decrement.
  - Ascending otherwise. Pointers start at src and dst and increment.
  - cmd_dst==cmd_src is legal and copied ascending.
- On a valid accept: rows_done cleared to 0, remaining count loaded with cmd_len.
- FSM states:
  - IDLE: cmd_ready=1. Valid accept -> RD.
  - RD: if arr_busy, arr_en=0 and hold in RD. Otherwise drive arr_en=1, arr_we=0, arr_addr=src_ptr for one cycle -> WAIT.
  - WAIT: count RD_LAT cycles. Capture arr_rdata into the data register on the RD_LAT-th cycle after RD -> WR.
  - WR: if arr_busy, hold with arr_en=0; the data register is held. Otherwise drive arr_en=1, arr_we=1, arr_addr=dst_ptr, arr_wdata=data register. Increment rows_done, step both pointers, decrement remaining. Remaining becomes 0 -> DONE, else -> RD.
  - DONE: done_irq=1 for one cycle -> IDLE.
- Throughput: 2+RD_LAT cycles per row with arr_busy low. Latency from accept to done_irq is len*(2+RD_LAT)+1 cycles.
- arr_addr and arr_wdata are registered-stable throughout any arr_en cycle. arr_addr is 0 when arr_en=0.
- Pointer arithmetic uses ROW_AW+1 bits internally. The acceptance checks guarantee no wrap-around, so address 2**ROW_AW-1 is reachable and nothing wraps to row 0.
- Abort while not IDLE:
  - Next state is IDLE. err_irq pulses once; done_irq is not pulsed.
  - The abort-cycle access is suppressed: arr_en is forced to 0 combinationally.
  - rows_done holds the number of completed writes.
- Abort in IDLE is ignored.
- Simultaneous abort and the final WR: abort wins. The write is suppressed, err_irq fires, done_irq does not.
- cmd_valid outside IDLE is ignored (cmd_ready=0). The command inputs are sampled only on accept.

Decomposition:
- Shared package cim_pkg:
  - FSM state enum: IDLE, RD, WAIT, WR, DONE.
  - Default ROW_AW and DATA_W constants.
  - Direction encoding DIR_ASC/DIR_DESC.
- One natural sub-module, cim_cmd_checker: combinational range, length and overlap check producing cmd_ok and dir. It is reused by the row-copy path.

Test Plan:
- src=4, dst=20, len=3, RD_LAT=1, arr_busy=0 -> reads 4,5,6 and writes 20,21,22 with matching data; done_irq at accept+10; rows_done=3.
- src=10, dst=12, len=4 (overlap) -> reads 13,12,11,10 and writes 15,14,13,12 in that order; destination holds the original rows 10..13.
- len=0, then src=250, len=8 (ROW_AW=8) -> err_irq pulse each time, no arr_en, cmd_ready stays 1.
- arr_busy high for 5 cycles during the second WR of a len=2 copy -> arr_en=0 during the stall, write data unchanged, done_irq delayed by 5 cycles.
- abort asserted in the WAIT of row 3 of len=5 -> no further arr_en, err_irq once, rows_done=2, returns to IDLE next cycle; a new command is then accepted normally.
- rst_n low mid-copy -> all outputs at reset values immediately, cmd_ready=1 after release.
